// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Brief    : RV32I ALU (single cycle) plus iterative RV32M multiply/divide,
//            valid/ready on both sides with a registered result.
// Revision : 1.0
// ============================================================================
module alu_muldiv #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] operands_a_i,
  input  logic [DATA_WIDTH-1:0] operands_b_i,
  input  logic [4:0]            alu_op_i,
  input  logic                  invert_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  div_zero_o
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0]  ITERATIONS = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [4:0] OP_ADD_SUB = 5'd0;
  localparam logic [4:0] OP_SLL     = 5'd1;
  localparam logic [4:0] OP_SLT     = 5'd2;
  localparam logic [4:0] OP_SLTU    = 5'd3;
  localparam logic [4:0] OP_XOR     = 5'd4;
  localparam logic [4:0] OP_SRL_SRA = 5'd5;
  localparam logic [4:0] OP_OR      = 5'd6;
  localparam logic [4:0] OP_AND     = 5'd7;
  localparam logic [4:0] OP_MUL     = 5'd8;
  localparam logic [4:0] OP_MULH    = 5'd9;
  localparam logic [4:0] OP_MULHSU  = 5'd10;
  localparam logic [4:0] OP_DIV     = 5'd12;
  localparam logic [4:0] OP_DIVU    = 5'd13;
  localparam logic [4:0] OP_REM     = 5'd14;
  localparam logic [4:0] OP_REMU    = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_WIDTH-1:0]    count;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0]   opnd;
  logic                    neg;
  logic                    sel_hi;

  logic                    pend;
  logic [DATA_WIDTH-1:0]   pend_result;
  logic                    pend_div_zero;

  logic out_free, accept, done_we, out_we, out_div_zero;
  logic [DATA_WIDTH-1:0] out_data;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic is_mul, is_div, is_iter, a_signed, b_signed, a_neg, b_neg;
  logic b_zero, div_ovf;
  logic [DATA_WIDTH-1:0]  mag_a, mag_b, sra_result, base_result;
  logic                   base_div_zero;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign out_free = !valid_o || ready_i;
  assign ready_o  = (state == IDLE) && out_free;
  assign accept   = valid_i && ready_o;

  assign is_mul   = (alu_op_i[4:2] == 3'b010);
  assign is_div   = (alu_op_i[4:2] == 3'b011);
  assign a_signed = (alu_op_i == OP_MULH) || (alu_op_i == OP_MULHSU) ||
                    (alu_op_i == OP_DIV)  || (alu_op_i == OP_REM);
  assign b_signed = (alu_op_i == OP_MULH) || (alu_op_i == OP_DIV) ||
                    (alu_op_i == OP_REM);
  assign a_neg    = a_signed && operands_a_i[DATA_WIDTH-1];
  assign b_neg    = b_signed && operands_b_i[DATA_WIDTH-1];
  assign mag_a    = a_neg ? -operands_a_i : operands_a_i;
  assign mag_b    = b_neg ? -operands_b_i : operands_b_i;

  assign b_zero   = (operands_b_i == '0);
  assign div_ovf  = ((alu_op_i == OP_DIV) || (alu_op_i == OP_REM)) &&
                    (operands_a_i == MOST_NEG) && (operands_b_i == '1);
  // Divide special cases resolve immediately and never enter the DIV state.
  assign is_iter  = is_mul || (is_div && !b_zero && !div_ovf);

  assign shamt      = operands_b_i[SHAMT_WIDTH-1:0];
  assign sra_result = $signed(operands_a_i) >>> shamt;

  always_comb begin
    base_result   = '0;
    base_div_zero = 1'b0;
    case (alu_op_i)
      OP_ADD_SUB: base_result = invert_i ? (operands_a_i - operands_b_i)
                                         : (operands_a_i + operands_b_i);
      OP_SLL:     base_result = operands_a_i << shamt;
      OP_SLT:     base_result = {{(DATA_WIDTH-1){1'b0}},
                                 $signed(operands_a_i) < $signed(operands_b_i)};
      OP_SLTU:    base_result = {{(DATA_WIDTH-1){1'b0}}, operands_a_i < operands_b_i};
      OP_XOR:     base_result = operands_a_i ^ operands_b_i;
      OP_SRL_SRA: base_result = invert_i ? sra_result : (operands_a_i >> shamt);
      OP_OR:      base_result = operands_a_i | operands_b_i;
      OP_AND:     base_result = operands_a_i & operands_b_i;
      OP_DIV, OP_DIVU: begin
        if (b_zero) begin
          base_result   = '1;
          base_div_zero = 1'b1;
        end else if (div_ovf) begin
          base_result = operands_a_i;
        end
      end
      OP_REM, OP_REMU: begin
        if (b_zero) begin
          base_result   = operands_a_i;
          base_div_zero = 1'b1;
        end
      end
      default: base_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath: acc holds {hi, lo} for shift-add, {rem, quo} for divide
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0]     mul_sum, div_trial;
  logic [2*DATA_WIDTH-1:0] prod_signed;
  logic [DATA_WIDTH-1:0]   mul_result, div_pick, div_result;

  assign mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                     {1'b0, (acc[0] ? opnd : {DATA_WIDTH{1'b0}})};
  assign div_trial = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]} -
                     {1'b0, opnd};

  assign prod_signed = neg ? -acc : acc;
  assign mul_result  = sel_hi ? prod_signed[2*DATA_WIDTH-1:DATA_WIDTH]
                              : prod_signed[DATA_WIDTH-1:0];
  assign div_pick    = sel_hi ? acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[DATA_WIDTH-1:0];
  assign div_result  = neg ? -div_pick : div_pick;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg    <= 1'b0;
      sel_hi <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && is_iter) begin
        count  <= ITERATIONS;
        acc    <= {{DATA_WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
        opnd   <= is_mul ? mag_a : mag_b;
        neg    <= (is_div && alu_op_i[1]) ? a_neg : (a_neg ^ b_neg);
        sel_hi <= is_mul ? (alu_op_i != OP_MUL) : alu_op_i[1];
      end
    end else if (count != '0) begin
      count <= count - CNT_ONE;
      if (state == MUL) begin
        acc <= {mul_sum, acc[DATA_WIDTH-1:1]};
      end else if (!div_trial[DATA_WIDTH]) begin
        acc <= {div_trial[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc <= {acc[2*DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM; count==0 in MUL/DIV is the done-and-waiting condition
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done_we    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_iter) begin
          state_next = is_mul ? MUL : DIV;
        end
      end
      MUL, DIV: begin
        if ((count == '0) && out_free) begin
          done_we    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ops are staged one edge before reaching the output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend          <= 1'b0;
      pend_result   <= '0;
      pend_div_zero <= 1'b0;
    end else if (accept && !is_iter) begin
      pend          <= 1'b1;
      pend_result   <= base_result;
      pend_div_zero <= base_div_zero;
    end else if (out_free) begin
      pend <= 1'b0;
    end
  end

  always_comb begin
    out_we       = 1'b0;
    out_data     = pend_result;
    out_div_zero = pend_div_zero;
    if (pend && out_free) begin
      out_we = 1'b1;
    end else if (done_we) begin
      out_we       = 1'b1;
      out_data     = (state == MUL) ? mul_result : div_result;
      out_div_zero = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      div_zero_o <= 1'b0;
    end else if (out_we) begin
      valid_o    <= 1'b1;
      result_o   <= out_data;
      zero_o     <= (out_data == '0);
      div_zero_o <= out_div_zero;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Brief    : Scoreboard bench for alu_muldiv (directed cases plus model-checked
//            random ops under random output back-pressure).
// Revision : 1.0
// ============================================================================
module tb_alu_muldiv;

  localparam logic [4:0] OP_ADD_SUB = 5'd0;
  localparam logic [4:0] OP_XOR     = 5'd4;
  localparam logic [4:0] OP_SRL_SRA = 5'd5;
  localparam logic [4:0] OP_OR      = 5'd6;
  localparam logic [4:0] OP_AND     = 5'd7;
  localparam logic [4:0] OP_MUL     = 5'd8;
  localparam logic [4:0] OP_MULH    = 5'd9;
  localparam logic [4:0] OP_MULHU   = 5'd11;
  localparam logic [4:0] OP_DIV     = 5'd12;
  localparam logic [4:0] OP_DIVU    = 5'd13;
  localparam logic [4:0] OP_REM     = 5'd14;
  localparam logic [4:0] OP_REMU    = 5'd15;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] operands_a_i = '0;
  logic [31:0] operands_b_i = '0;
  logic [4:0]  alu_op_i = '0;
  logic        invert_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        zero_o;
  logic        div_zero_o;

  alu_muldiv #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .operands_a_i (operands_a_i),
    .operands_b_i (operands_b_i),
    .alu_op_i     (alu_op_i),
    .invert_i     (invert_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .zero_o       (zero_o),
    .div_zero_o   (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp;
  int   total = 0;
  int   bad = 0;
  int   last_waits = 0;
  bit   rnd_ready = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference for the RV32I/RV32M semantics.
  function automatic logic [32:0] ref_model(input logic [4:0] op, input logic inv,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        dz;
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    r  = '0;
    dz = 1'b0;
    sa = a;
    sb = b;
    case (op)
      5'd0:  r = inv ? a - b : a + b;
      5'd1:  r = a << b[4:0];
      5'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd3:  r = (a < b) ? 32'd1 : 32'd0;
      5'd4:  r = a ^ b;
      5'd5:  r = inv ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      5'd6:  r = a | b;
      5'd7:  r = a & b;
      5'd8:  begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
      5'd9:  begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
      5'd10: begin sp = longint'(sa) * longint'({32'b0, b}); r = sp[63:32]; end
      5'd11: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      5'd12: begin
        if (b == 0) begin r = '1; dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'(sa / sb);
      end
      5'd13: begin
        if (b == 0) begin r = '1; dz = 1'b1; end
        else r = a / b;
      end
      5'd14: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = 32'(sa % sb);
      end
      5'd15: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else r = a % b;
      end
      default: r = '0;
    endcase
    return {dz, r};
  endfunction

  // Results are popped where the output handshake will complete on the next edge.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_exp = sb_q.pop_front();
        check({mon_exp.tag, "_result"}, result_o, mon_exp.res);
        check({mon_exp.tag, "_divzero"}, div_zero_o, mon_exp.dz);
        check({mon_exp.tag, "_zero"}, zero_o, (mon_exp.res == 32'd0));
      end
    end
  end

  always @(posedge clk_i) begin
    if (rnd_ready) begin
      #1;
      ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input string tag, input logic [4:0] op, input logic inv,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input logic dz);
    int waits;
    waits        = 0;
    valid_i      = 1'b1;
    alu_op_i     = op;
    invert_i     = inv;
    operands_a_i = a;
    operands_b_i = b;
    @(negedge clk_i);
    while (!ready_o && waits < 300) begin
      waits++;
      @(negedge clk_i);
    end
    if (ready_o) sb_q.push_back('{tag, exp, dz});
    else check({tag, "_accept_timeout"}, ready_o, 1'b1);
    last_waits = waits;
    @(posedge clk_i);
    #1;
    valid_i      = 1'b0;
    alu_op_i     = 5'($urandom);
    invert_i     = 1'($urandom);
    operands_a_i = $urandom;
    operands_b_i = $urandom;
  endtask

  task automatic send_model(input string tag, input logic [4:0] op, input logic inv,
                            input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    m = ref_model(op, inv, a, b);
    send(tag, op, inv, a, b, m[31:0], m[32]);
  endtask

  task automatic measure(input string tag, input int want, input bit iter);
    int n;
    int busy;
    n    = 0;
    busy = 0;
    @(negedge clk_i);
    while (!valid_o && n < 100) begin
      n++;
      if (ready_o) busy++;
      @(negedge clk_i);
    end
    check({tag, "_latency"}, n, want);
    if (iter) check({tag, "_ready_low"}, busy, 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 600) begin
      @(posedge clk_i);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int b2b;
    int n;
    int seen;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_result", result_o, 32'h0);
    check("rst_zero", zero_o, 1'b1);
    check("rst_divzero", div_zero_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    send("sub", OP_ADD_SUB, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    measure("sub", 1, 1'b0);
    send("sra", OP_SRL_SRA, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    measure("sra", 1, 1'b0);
    drain();

    b2b = 0;
    send("b2b_xor", OP_XOR, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0);
    b2b += last_waits;
    send("b2b_and", OP_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0);
    b2b += last_waits;
    send("b2b_or", OP_OR, 1'b0, 32'hF0F0_1234, 32'h0FF0_0000, 32'hFFF0_1234, 1'b0);
    b2b += last_waits;
    check("b2b_ready_waits", b2b, 0);
    drain();

    send("mulh", OP_MULH, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
    measure("mulh", 33, 1'b1);
    send("mulhu", OP_MULHU, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0);
    measure("mulhu", 33, 1'b1);
    send("mul", OP_MUL, 1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0);
    measure("mul", 33, 1'b1);
    send("div", OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    measure("div", 33, 1'b1);
    send("rem", OP_REM, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    measure("rem", 33, 1'b1);
    send("divu", OP_DIVU, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
    measure("divu", 33, 1'b1);
    send("remu", OP_REMU, 1'b0, 32'd100, 32'd7, 32'd2, 1'b0);
    measure("remu", 33, 1'b1);

    send("divu_by0", OP_DIVU, 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1);
    measure("divu_by0", 1, 1'b0);
    send("rem_by0", OP_REM, 1'b0, 32'd9, 32'd0, 32'd9, 1'b1);
    measure("rem_by0", 1, 1'b0);
    send("div_ovf", OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    measure("div_ovf", 1, 1'b0);
    send("rem_ovf", OP_REM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    measure("rem_ovf", 1, 1'b0);
    drain();

    // Completion under back-pressure, with an ignored request while busy.
    ready_i = 1'b0;
    send("mul_stall", OP_MUL, 1'b0, 32'd7, 32'd6, 32'd42, 1'b0);
    n = 0;
    @(negedge clk_i);
    while (!valid_o && n < 60) begin
      n++;
      @(negedge clk_i);
    end
    check("stall_latency", n, 33);
    valid_i      = 1'b1;
    alu_op_i     = OP_ADD_SUB;
    invert_i     = 1'b0;
    operands_a_i = 32'd1;
    operands_b_i = 32'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("stall_valid", valid_o, 1'b1);
      check("stall_result", result_o, 32'd42);
      check("stall_ready", ready_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("release_valid", valid_o, 1'b0);
    drain();

    rnd_ready = 1;
    for (int i = 0; i < 24; i++) begin
      send_model($sformatf("rnd%0d", i), 5'($urandom_range(0, 31)), 1'($urandom),
                 pick_operand(), pick_operand());
    end
    rnd_ready = 0;
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    drain();

    // Asynchronous reset in the middle of a divide discards it.
    send("div_rst", OP_DIV, 1'b0, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_result", result_o, 32'h0);
    check("midrst_zero", zero_o, 1'b1);
    sb_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("midrst_ready", ready_o, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check("midrst_no_stale", seen, 0);
    @(posedge clk_i);
    #1;
    send("post_rst_add", OP_ADD_SUB, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0);
    measure("post_rst_add", 1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Sequential successor to the combinational integer ALU. It executes the RV32I base ALU ops in one cycle and the RV32M multiply/divide ops iteratively. Operands enter and results leave through valid/ready handshakes. It sits in the execute stage and stalls the pipeline through ready_o while a long op is in flight.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even and at least 8.
SHAMT_WIDTH, 5, shift-amount bits taken from operands_b_i; must equal log2(DATA_WIDTH).

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  operation request valid
ready_o  out  1  block can accept a request
operands_a_i  in  DATA_WIDTH  operand A / dividend / multiplicand
operands_b_i  in  DATA_WIDTH  operand B / divisor / multiplier / shift amount
alu_op_i  in  5  operation code
invert_i  in  1  SUB for ADD_SUB, SRA for SRL_SRA; ignored otherwise
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_o  out  DATA_WIDTH  registered result
zero_o  out  1  registered, result_o == 0
div_zero_o  out  1  registered; result came from a divide/remainder by zero

Behaviour:
- Opcodes:
  - 0 ADD_SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL_SRA, 6 OR, 7 AND
  - 8 MUL, 9 MULH, 10 MULHSU, 11 MULHU
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU
  - 16-31 illegal: result 0, latency 1, no error flag
- Accept: a request is taken on a rising edge where valid_i && ready_o. Operands and op are captured at that edge, so inputs may change afterwards.
- ready_o = (state==IDLE) && (!valid_o || ready_i).
- Output register:
  - valid_o, result_o, zero_o and div_zero_o hold while valid_o && !ready_i.
  - valid_o clears on the edge where ready_i is seen, unless a new result is written on that same edge.
- State machine IDLE, MUL, DIV:
  - IDLE: accepting base op, illegal op or DIV special case -> write output next edge, stay IDLE (latency 1). Accepting a multiply -> MUL. Accepting a divide -> DIV.
  - MUL:
    - Take operand magnitudes per signedness: MULH both signed; MULHSU A signed, B unsigned; MUL and MULHU unsigned.
    - Shift-add one multiplier bit per cycle into a 2*DATA_WIDTH accumulator; iteration counter starts at DATA_WIDTH.
    - After DATA_WIDTH iterations, negate the product if the signs differ, write the low half (MUL) or high half (others), go to IDLE.
  - DIV:
    - Restoring division, one quotient bit per cycle, on magnitudes (DIV/REM signed).
    - After DATA_WIDTH iterations, quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
    - Write the quotient (DIV/DIVU) or remainder (REM/REMU), go to IDLE.
- Latency: accept at edge k; base op valid_o high after edge k+1. Iterative op valid_o high after edge k+DATA_WIDTH+1 (33 for the default width). Throughput is 1 per cycle for base ops.
- Divide special cases (resolved at accept, latency 1, no DIV state):
  - B==0: quotient all-ones; remainder = A; div_zero_o=1.
  - Signed overflow (A = most-negative, B = -1): DIV result = A; REM result = 0; div_zero_o=0.
- Shifts use operands_b_i[SHAMT_WIDTH-1:0]. SRA sign-fills.
- SLT/SLTU results are 1 or 0, zero-extended.
- ADD/SUB wrap modulo 2^DATA_WIDTH.
- Output stall at completion: the iterative result waits in the internal register, in a DONE sub-condition of MUL/DIV, until the output register is free. The iteration counter holds and ready_o stays 0.
- Reset (asynchronous, any time including mid-iteration): state=IDLE, counter=0, valid_o=0, result_o=0, zero_o=1, div_zero_o=0. The in-flight op is discarded. ready_o=1 combinationally after reset deasserts.
- valid_i while ready_o=0 is ignored; it is not queued.

Test Plan:
- ADD_SUB invert_i=1, A=5, B=7, ready_i=1 -> valid_o one cycle after accept; result_o=0xFFFFFFFE, zero_o=0. SRL_SRA invert_i=1, A=0x80000000, B=4 -> 0xF8000000.
- Back-to-back base ops XOR, AND, OR on consecutive cycles with ready_i=1 -> ready_o stays 1; three consecutive results, one per cycle.
- MULH A=0xFFFFFFFF (-1), B=2 -> result 0xFFFFFFFF after exactly 33 cycles; ready_o=0 throughout. MULHU same operands -> 0x00000001. MUL 0x12345678 * 0x10 -> 0x23456780.
- DIV A=-7, B=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14; REMU -> 2; each 33 cycles.
- DIVU A=9, B=0 -> 0xFFFFFFFF with div_zero_o=1, latency 1. REM 9, 0 -> 9. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, div_zero_o=0.
- Hold ready_i=0 during a MUL completion -> result_o and valid_o stable, ready_o=0. Raise ready_i -> valid_o drops next edge unless a new op completes. Assert rst_i at cycle 10 of a DIV -> valid_o=0 immediately, ready_o=1 after release, no stale result.
